// File: rtl/gray_to_bin.sv
// Registered Gray-code to binary converter for the receive side of CDC pointer paths.
// One conversion per clock, one clock of latency, output cleared asynchronously by rst_i.
module gray_to_bin #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] in_data_i,
   output logic [WIDTH-1:0] out_data_o
);

   // Each binary bit is the XOR of all Gray bits at and above its position.
   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [WIDTH-1:0] bin_p0;

   // Stage 0: combinational decode of the sampled Gray input
   always_comb begin
      bin_p0 = gray2bin(in_data_i);
   end

   // Stage 1: output register; cleared on reset so downstream never sees a stale pointer
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_data_o <= '0;
      end else begin
         out_data_o <= bin_p0;
      end
   end

endmodule

// File: tb/tb_gray_to_bin.sv
// Self-checking bench for gray_to_bin at WIDTH = 1, 4 and 8 driven from a shared clock.
// Expected values come from inverse lookup tables built by forward Gray encoding n ^ (n >> 1).
module tb_gray_to_bin;

   logic       clk;
   logic       rst;
   logic [0:0] g1;
   logic [3:0] g4;
   logic [7:0] g8;
   logic [0:0] b1;
   logic [3:0] b4;
   logic [7:0] b8;

   int compared   = 0;
   int mismatched = 0;

   int tbl1 [2];
   int tbl4 [16];
   int tbl8 [256];

   gray_to_bin #(.WIDTH(1)) u_w1 (.clk_i(clk), .rst_i(rst), .in_data_i(g1), .out_data_o(b1));
   gray_to_bin #(.WIDTH(4)) u_w4 (.clk_i(clk), .rst_i(rst), .in_data_i(g4), .out_data_o(b4));
   gray_to_bin #(.WIDTH(8)) u_w8 (.clk_i(clk), .rst_i(rst), .in_data_i(g8), .out_data_o(b8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Apply one Gray value (truncated per width) at a falling edge, then check one clock later.
   task automatic step(input int g, input string tag);
      @(negedge clk);
      g1 = g[0:0];
      g4 = g[3:0];
      g8 = g[7:0];
      @(posedge clk);
      #1;
      check({tag, "_w1"}, int'(b1), tbl1[g & 1]);
      check({tag, "_w4"}, int'(b4), tbl4[g & 15]);
      check({tag, "_w8"}, int'(b8), tbl8[g & 255]);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_w1"}, int'(b1), 0);
      check({tag, "_w4"}, int'(b4), 0);
      check({tag, "_w8"}, int'(b8), 0);
   endtask

   initial begin
      bit seen4 [16];
      bit seen8 [256];
      int distinct4;
      int distinct8;
      int r;

      for (int n = 0; n < 2; n++)   tbl1[n ^ (n >> 1)] = n;
      for (int n = 0; n < 16; n++)  tbl4[n ^ (n >> 1)] = n;
      for (int n = 0; n < 256; n++) tbl8[n ^ (n >> 1)] = n;

      // Reset held across several edges, with a non-zero input present.
      rst = 1'b1;
      g1  = 1'b1;
      g4  = 4'hF;
      g8  = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check_all_zero("reset_hold");
      end
      @(negedge clk);
      rst = 1'b0;

      // Directed sequences and boundary mappings.
      step(32'h0, "seq0");
      step(32'h1, "seq1");
      step(32'h2, "seq2");
      step(32'h3, "seq3");
      step(32'h4, "seq4");
      step(32'h5, "seq5");
      step(32'h6, "seq6");
      step(32'h7, "seq7");
      step(32'h8, "msb_only");
      check("msb_only_abs", int'(b4), 32'hF);
      step(32'hC, "gC");
      check("gC_abs", int'(b4), 32'h8);
      step(32'hF, "all_ones");
      check("all_ones_abs", int'(b4), 32'hA);
      step(32'h80, "w8_msb");
      check("w8_msb_abs", int'(b8), 32'hFF);
      step(32'hFF, "w8_ones");
      check("w8_ones_abs", int'(b8), 32'hAA);

      // Asynchronous reset pulse between edges, with gray 0xF applied.
      #1;
      rst = 1'b1;
      #1;
      check_all_zero("async_pulse");
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("after_pulse_w4", int'(b4), 32'hA);
      check("after_pulse_w8", int'(b8), 32'hAA);

      // Mid-stream reset held across an edge, released, next edge gives 0xA again.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("midstream_rst");
      @(posedge clk);
      #1;
      check_all_zero("midstream_rst_edge");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midstream_release_w4", int'(b4), 32'hA);

      // Exhaustive sweep for every width; track distinctness of outputs.
      foreach (seen4[i]) seen4[i] = 1'b0;
      foreach (seen8[i]) seen8[i] = 1'b0;
      for (int i = 0; i < 256; i++) begin
         step(i, "sweep");
         if (i < 16) seen4[b4] = 1'b1;
         seen8[b8] = 1'b1;
      end
      distinct4 = 0;
      distinct8 = 0;
      foreach (seen4[i]) distinct4 += int'(seen4[i]);
      foreach (seen8[i]) distinct8 += int'(seen8[i]);
      check("distinct_w4", distinct4, 16);
      check("distinct_w8", distinct8, 256);

      // Random back-to-back traffic.
      for (int k = 0; k < 200; k++) begin
         r = int'($urandom_range(0, 255));
         step(r, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Global watchdog so the run cannot hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
